// File: rtl/button_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_counter_pkg
//  Description : Shared types and helpers for the debounced up/down button
//                counter: debouncer FSM state encoding and the elaboration-time
//                computation of the debounce interval in clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_counter_pkg;

  // Debouncer states; a button is either settled (IDLE/PRESSED) or waiting
  // for its new level to stay stable long enough (ARM_PRESS/ARM_RELEASE).
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } deb_state_e;

  // Number of clock cycles a synchronized level must remain stable.
  function automatic int unsigned calc_deb_cycles(input int unsigned clk_freq,
                                                  input int unsigned debounce_ms);
    return (clk_freq / 1000) * debounce_ms;
  endfunction

endpackage : button_counter_pkg
`default_nettype wire

// File: rtl/button_counter_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Debounces one raw active-low push-button. Two-flop
//                synchronizer, four-state stability FSM and a stability
//                counter; emits a registered one-cycle pulse per accepted press.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
  import button_counter_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pulse
);

  // A counter of CNT_W bits can reach DEB_CYCLES-1; guard the degenerate
  // case so the width is never zero (the top rejects DEB_CYCLES < 2).
  localparam int unsigned    CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q,  sync_d;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             pulse_q, pulse_d;
  logic             w_pressed;

  // Synchronizer shift: bit 0 samples the raw pin, bit 1 is the safe copy.
  always_comb begin
    sync_d = {sync_q[0], btn_n};
  end

  // Buttons are active-low; the FSM works on a positive "pressed" sense.
  assign w_pressed = ~sync_q[1];

  // Synchronizer flops reset to the released level (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Next-state, stability counter and pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_pressed) begin
          state_d = ARM_PRESS;
          cnt_d   = '0;
        end
      end
      ARM_PRESS: begin
        if (!w_pressed) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!w_pressed) begin
          state_d = ARM_RELEASE;
          cnt_d   = '0;
        end
      end
      ARM_RELEASE: begin
        // A bounce back to pressed resumes PRESSED silently, so a held
        // button never produces a second pulse.
        if (w_pressed) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and pulse registers; reset aborts any debounce in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/button_counter.sv
`default_nettype none
// ============================================================================
//  Module      : button_counter
//  Description : 8-bit up/down counter driven by two debounced active-low
//                push-buttons. Counts modulo 256 or saturates, per WRAP.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_counter
  import button_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned WRAP        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [7:0] leds,
  output logic       pulse_up,
  output logic       pulse_down
);

  localparam int unsigned DEB_CYCLES = calc_deb_cycles(CLK_FREQ, DEBOUNCE_MS);

  // The FSM needs at least two stable samples to tell a press from noise.
  if (DEB_CYCLES < 2) begin : g_deb_check
    $error("button_counter: DEB_CYCLES must be >= 2");
  end

  logic [7:0] leds_q, leds_d;
  logic       w_pulse_up;
  logic       w_pulse_down;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_up),
    .pulse (w_pulse_up)
  );

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_down (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_down),
    .pulse (w_pulse_down)
  );

  // Count update: simultaneous up and down cancel; WRAP=0 clamps at the ends.
  always_comb begin
    leds_d = leds_q;
    case ({w_pulse_up, w_pulse_down})
      2'b10: begin
        if ((WRAP != 0) || (leds_q != 8'hFF)) begin
          leds_d = leds_q + 8'd1;
        end
      end
      2'b01: begin
        if ((WRAP != 0) || (leds_q != 8'h00)) begin
          leds_d = leds_q - 8'd1;
        end
      end
      default: begin
        leds_d = leds_q;
      end
    endcase
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= 8'd0;
    end else begin
      leds_q <= leds_d;
    end
  end

  assign leds       = leds_q;
  assign pulse_up   = w_pulse_up;
  assign pulse_down = w_pulse_down;

endmodule : button_counter
`default_nettype wire

// File: tb/tb_button_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_counter
//  Description : Directed self-checking bench for button_counter with
//                CLK_FREQ=1000, DEBOUNCE_MS=4 (DEB_CYCLES=4). Instance A wraps,
//                instance B saturates; both share clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_counter;

  logic       clk;
  logic       rst_n;
  logic       up_a, dn_a, up_b, dn_b;
  logic [7:0] leds_a, leds_b;
  logic       pulse_up_a, pulse_down_a, pulse_up_b, pulse_down_b;

  int checks;
  int errors;
  int pu_a, pd_a, pu_b, pd_b;
  int pu0, pd0;

  button_counter #(
    .CLK_FREQ    (1000),
    .DEBOUNCE_MS (4),
    .WRAP        (1)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (up_a),
    .btn_down   (dn_a),
    .leds       (leds_a),
    .pulse_up   (pulse_up_a),
    .pulse_down (pulse_down_a)
  );

  button_counter #(
    .CLK_FREQ    (1000),
    .DEBOUNCE_MS (4),
    .WRAP        (0)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (up_b),
    .btn_down   (dn_b),
    .leds       (leds_b),
    .pulse_up   (pulse_up_b),
    .pulse_down (pulse_down_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (pulse_up_a)   pu_a++;
    if (pulse_down_a) pd_a++;
    if (pulse_up_b)   pu_b++;
    if (pulse_down_b) pd_b++;
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Press the selected buttons for 'hold' cycles, release, let them settle.
  task automatic press(input bit au, input bit ad, input bit bu, input bit bd,
                       input int hold);
    if (au) up_a = 1'b0;
    if (ad) dn_a = 1'b0;
    if (bu) up_b = 1'b0;
    if (bd) dn_b = 1'b0;
    tick(hold);
    up_a = 1'b1; dn_a = 1'b1; up_b = 1'b1; dn_b = 1'b1;
    tick(12);
  endtask

  initial begin
    checks = 0; errors = 0;
    pu_a = 0; pd_a = 0; pu_b = 0; pd_b = 0;
    up_a = 1'b1; dn_a = 1'b1; up_b = 1'b1; dn_b = 1'b1;
    rst_n = 1'b0;

    // Reset state
    tick(2);
    check("rst_leds", leds_a, 0);
    check("rst_pulse_up", pulse_up_a, 0);
    check("rst_pulse_down", pulse_down_a, 0);
    rst_n = 1'b1;
    tick(2);

    // Clean press: pulse in the cycle after edge k+6, leds one cycle later
    pu0 = pu_a;
    up_a = 1'b0;
    tick(6);
    check("lat_pulse_early", pulse_up_a, 0);
    tick(1);
    check("lat_pulse", pulse_up_a, 1);
    check("lat_leds_before", leds_a, 0);
    tick(1);
    check("lat_pulse_one_cycle", pulse_up_a, 0);
    check("lat_leds_after", leds_a, 1);
    tick(12);
    up_a = 1'b1;
    tick(12);
    check("held_single_pulse", pu_a - pu0, 1);
    check("held_leds", leds_a, 1);

    // Short glitches never qualify
    do_reset();
    pu0 = pu_a;
    for (int i = 0; i < 5; i++) begin
      up_a = 1'b0;
      tick(3);
      up_a = 1'b1;
      tick(5);
    end
    tick(8);
    check("glitch_pulses", pu_a - pu0, 0);
    check("glitch_leds", leds_a, 0);

    // Down at zero: wrap goes to 255, saturate holds at 0 but still pulses
    do_reset();
    pd0 = pd_b;
    press(1'b0, 1'b1, 1'b0, 1'b1, 8);
    check("wrap_down_at_0", leds_a, 255);
    check("sat_down_at_0", leds_b, 0);
    check("sat_down_pulse", pd_b - pd0, 1);

    // 256 up presses: wrap 0..255 then 0; saturate stops at 255
    do_reset();
    pu0 = pu_b;
    for (int i = 0; i < 256; i++) begin
      press(1'b1, 1'b0, 1'b1, 1'b0, 8);
      check("wrap_up_leds", leds_a, (i + 1) % 256);
      check("sat_up_leds", leds_b, (i < 255) ? i + 1 : 255);
    end
    check("sat_up_pulses", pu_b - pu0, 256);
    press(1'b0, 1'b1, 1'b0, 1'b0, 8);
    check("wrap_down_from_0", leds_a, 255);

    // Simultaneous up and down from 7 leave the count unchanged
    do_reset();
    for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 1'b0, 1'b0, 8);
    check("both_pre_leds", leds_a, 7);
    up_a = 1'b0; dn_a = 1'b0;
    tick(7);
    check("both_pulse_up", pulse_up_a, 1);
    check("both_pulse_down", pulse_down_a, 1);
    tick(1);
    check("both_leds_next", leds_a, 7);
    up_a = 1'b1; dn_a = 1'b1;
    tick(12);
    check("both_leds_final", leds_a, 7);

    // Reset two cycles into ARM_PRESS, button still held afterwards
    do_reset();
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0, 1'b0, 8);
    check("rstmid_pre_leds", leds_a, 5);
    pu0 = pu_a;
    up_a = 1'b0;
    tick(5);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_leds_now", leds_a, 0);
    check("rstmid_pulse_now", pulse_up_a, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("rstmid_no_pulse_yet", pu_a - pu0, 0);
    tick(1);
    check("rstmid_pulse", pulse_up_a, 1);
    tick(1);
    check("rstmid_leds", leds_a, 1);
    up_a = 1'b1;
    tick(12);
    check("rstmid_pulse_count", pu_a - pu0, 1);

    // Release bounce of 2 cycles while PRESSED yields no second pulse
    do_reset();
    pu0 = pu_a;
    up_a = 1'b0;
    tick(10);
    up_a = 1'b1;
    tick(2);
    up_a = 1'b0;
    tick(10);
    check("bounce_pulses_held", pu_a - pu0, 1);
    up_a = 1'b1;
    tick(12);
    check("bounce_pulses", pu_a - pu0, 1);
    check("bounce_leds", leds_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_button_counter
`default_nettype wire
